// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with Z/C/N/V status flags.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> op 111 is an unsigned shift-add multiplier taking WIDTH
//                iterations (one per cycle) in the MUL_BUSY state.
//   undefined -> no multiplier hardware; op 111 finishes in one cycle with
//                result=0, zero=1 and all other flags 0.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake (a, b, alu_op)
//   a, b                 operands; shifts use b[SHW-1:0] as the amount
//   alu_op               000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                        101 SLL, 110 SRL, 111 MUL
//   out_valid / out_ready result handshake
//   result               registered result
//   zero, carry, negative, overflow  registered status flags
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
`ifdef ALU_MUL_EN
    S_MUL_BUSY = 2'd2,
`endif
    S_DONE     = 2'd1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_res_t;

  // Single-cycle operations. Op 111 (and any unused encoding) yields all zeros.
  function automatic alu_res_t alu_compute(input logic [WIDTH-1:0] op_a,
                                           input logic [WIDTH-1:0] op_b,
                                           input logic [2:0]       op);
    logic [WIDTH:0]   wide;
    logic [SHW-1:0]   sh;
    alu_res_t         r;
    r    = '0;
    wide = '0;
    sh   = op_b[SHW-1:0];
    case (op)
      OP_ADD: begin
        wide  = {1'b0, op_a} + {1'b0, op_b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (wide[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        wide  = {1'b0, op_a} - {1'b0, op_b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (wide[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: r.res = op_a & op_b;
      OP_OR:  r.res = op_a | op_b;
      OP_XOR: r.res = op_a ^ op_b;
      OP_SLL: begin
        // One guard bit above the MSB catches the last bit shifted out.
        wide  = {1'b0, op_a} << sh;
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
      end
      OP_SRL: begin
        // One guard bit below the LSB catches the last bit shifted out.
        wide  = {op_a, 1'b0} >> sh;
        r.res = wide[WIDTH:1];
        r.c   = wide[0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, negative_q, overflow_q;
  alu_res_t         alu_r;

  assign alu_r = alu_compute(a, b, alu_op);

`ifdef ALU_MUL_EN
  localparam logic [2:0]     OP_MUL   = 3'b111;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mc_q, mc_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mp_q, mp_d;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc_q, acc_d; // partial product
  logic [SHW-1:0]     cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q + (mp_q[0] ? mc_q : '0);
    mc_d  = mc_q << 1;
    mp_d  = mp_q >> 1;
    cnt_d = cnt_q + SHW'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mc_q        <= '0;
      mp_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            if (alu_op == OP_MUL) begin
              mc_q    <= {{WIDTH{1'b0}}, a};
              mp_q    <= b;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MUL_BUSY;
            end else
`endif
            begin
              result_q    <= alu_r.res;
              zero_q      <= (alu_r.res == '0);
              negative_q  <= alu_r.res[WIDTH-1];
              carry_q     <= alu_r.c;
              overflow_q  <= alu_r.v;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
`ifdef ALU_MUL_EN
        S_MUL_BUSY: begin
          mc_q  <= mc_d;
          mp_q  <= mp_d;
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          // The last iteration's sum is registered directly as the result.
          if (cnt_q == CNT_LAST) begin
            result_q    <= acc_d[WIDTH-1:0];
            zero_q      <= (acc_d[WIDTH-1:0] == '0);
            negative_q  <= acc_d[WIDTH-1];
            carry_q     <= |acc_d[2*WIDTH-1:WIDTH];
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
  localparam bit MUL_ON  = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_ON  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, negative, overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_or  = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry),
    .negative(negative), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model_op(input int av, input int bv, input int op,
                                   output int res, output int c, output int v,
                                   output int lat);
    int mask, sa, sb, s, n, hi, lo;
    mask = (1 << W) - 1;
    hi   = (1 << (W - 1)) - 1;
    lo   = -(1 << (W - 1));
    sa   = (av > hi) ? av - (1 << W) : av;
    sb   = (bv > hi) ? bv - (1 << W) : bv;
    n    = bv % W;
    res = 0; c = 0; v = 0; lat = 1;
    case (op)
      0: begin s = av + bv; res = s & mask; c = int'(s > mask);
               s = sa + sb; v = int'(s > hi || s < lo); end
      1: begin s = av - bv; res = s & mask; c = int'(av < bv);
               s = sa - sb; v = int'(s > hi || s < lo); end
      2: res = av & bv;
      3: res = av | bv;
      4: res = av ^ bv;
      5: begin res = (av << n) & mask; c = (n == 0) ? 0 : (av >> (W - n)) & 1; end
      6: begin res = av >> n; c = (n == 0) ? 0 : (av >> (n - 1)) & 1; end
      default: begin
        lat = MUL_LAT;
        if (MUL_ON) begin s = av * bv; res = s & mask; c = int'((s >> W) != 0); end
      end
    endcase
  endfunction

  // Cycle-level compare process: pending op tracked as a latency countdown.
  int m_busy = 0, m_ov = 0, e_res = 0, e_c = 0, e_v = 0;
  initial begin
    int r, c, v, lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({zero, carry, negative, overflow}), 0);
        m_busy = 0; m_ov = 0;
      end else begin
        chk("mon_in_ready", int'(in_ready), int'(m_ov == 0 && m_busy == 0));
        chk("mon_out_valid", int'(out_valid), m_ov);
        if (m_ov != 0) begin
          chk("mon_result", int'(result), e_res);
          chk("mon_zero", int'(zero), int'(e_res == 0));
          chk("mon_carry", int'(carry), e_c);
          chk("mon_negative", int'(negative), (e_res >> (W - 1)) & 1);
          chk("mon_overflow", int'(overflow), e_v);
        end
        if (m_ov != 0) begin
          if (out_ready) m_ov = 0;
        end else if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) m_ov = 1;
        end else if (in_valid) begin
          model_op(int'(a), int'(b), int'(alu_op), r, c, v, lat);
          e_res = r; e_c = c; e_v = v;
          if (lat == 1) m_ov = 1; else m_busy = lat - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] op);
    bit done;
    done = 1'b0;
    a = av; b = bv; alu_op = op; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    if (lat < 0) chk("out_timeout", 0, 1);
  endtask

  task automatic expect_out(input string name, input int lat_exp, input int res,
                            input int z, input int c, input int n, input int v);
    int lat;
    wait_out(lat);
    chk({name, "_lat"}, lat, lat_exp);
    chk({name, "_res"}, int'(result), res);
    chk({name, "_flags"}, int'({zero, carry, negative, overflow}), (z << 3) | (c << 2) | (n << 1) | v);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_result", int'(result), 0);
    tick();

    do_op(8'hFF, 8'h01, 3'b000);
    expect_out("add_ff_01", 1, 'h00, 1, 1, 0, 0);
    @(negedge clk);
    chk("add_next_in_ready", int'(in_ready), 1);
    tick();

    do_op(8'h80, 8'h01, 3'b001);
    expect_out("sub_80_01", 1, 'h7F, 0, 0, 0, 1);
    do_op(8'h01, 8'h02, 3'b001);
    expect_out("sub_01_02", 1, 'hFF, 0, 1, 1, 0);
    do_op(8'h81, 8'h09, 3'b101);
    expect_out("sll_81_09", 1, 'h02, 0, 1, 0, 0);
    do_op(8'h01, 8'h00, 3'b110);
    expect_out("srl_01_00", 1, 'h01, 0, 0, 0, 0);
    do_op(8'h80, 8'h07, 3'b110);
    expect_out("srl_80_07", 1, 'h01, 0, 0, 0, 0);

    do_op(8'h10, 8'h11, 3'b111);
    if (MUL_ON) expect_out("mul_10_11", MUL_LAT, 'h10, 0, 1, 0, 0);
    else        expect_out("mul_10_11", MUL_LAT, 'h00, 1, 0, 0, 0);
    do_op(8'h0F, 8'h0F, 3'b111);
    if (MUL_ON) expect_out("mul_0f_0f", MUL_LAT, 'hE1, 0, 0, 1, 0);
    else        expect_out("mul_0f_0f", MUL_LAT, 'h00, 1, 0, 0, 0);

    // Backpressure: result held while new requests are presented and ignored.
    out_ready = 1'b0;
    do_op(8'hAA, 8'h55, 3'b100);
    begin
      int lat;
      wait_out(lat);
      chk("xor_lat", lat, 1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); alu_op = 3'b000;
      @(negedge clk);
      chk("bp_result", int'(result), 'hFF);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_hold", int'(out_valid), 1);
    tick();
    @(negedge clk);
    chk("bp_released_out_valid", int'(out_valid), 0);
    chk("bp_released_in_ready", int'(in_ready), 1);
    tick();

    // Reset in the middle of a multiply abandons it.
    do_op(8'h10, 8'h11, 3'b111);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_result", int'(result), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    do_op(8'h02, 8'h03, 3'b000);
    expect_out("post_rst_add", 1, 'h05, 0, 0, 0, 0);

    // Randomized traffic with random backpressure, checked by the compare process.
    rand_or = 1'b1;
    repeat (300) begin
      do_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's 8-bit combinational ALU.
- Registered result, status flags (Z/C/N/V), three extra ops (XOR, SLL, SRL) and an optional iterative multiplier.
- Sits between decode/register-read and writeback.
- Uses a valid/ready pair on input and output so multi-cycle ops can stall the pipeline.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, shift amount = b[SHW-1:0]
- alu_op  input  3  operation select
- out_valid  output  1  result/flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  carry/borrow/high-half flag
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, multiplier registers=0. Reset asserted mid-multiply abandons the operation; no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid, capture a/b/op.
    - Non-MUL: compute and register result/flags at that edge, go to DONE.
    - MUL: go to MUL_BUSY.
  - MUL_BUSY: in_ready=0. Runs WIDTH shift-add iterations, one per cycle, driven by a counter. After the last iteration, register result/flags and go to DONE.
  - DONE: in_ready=0, out_valid=1. Result/flags held stable until out_ready=1, then go to IDLE, clearing out_valid on that edge.
- Handshake: transfer occurs only when valid and ready are both high. Throughput is at most one op per 2 cycles; in_ready is low in DONE even when out_ready is high.
- Latency (in_valid accepted to out_valid high):
  - Non-MUL: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Ops (all modulo 2^WIDTH):
  - 000 ADD: a+b; carry = carry-out; overflow = signed overflow.
  - 001 SUB: a-b; carry = borrow (a<b unsigned); overflow = signed overflow.
  - 010 AND, 011 OR, 100 XOR: carry=0, overflow=0.
  - 101 SLL: a << b[SHW-1:0]; carry = last bit shifted out (0 if amount 0); overflow=0.
  - 110 SRL: logical a >> b[SHW-1:0]; carry = last bit shifted out (0 if amount 0); overflow=0.
  - 111 MUL: unsigned, low WIDTH bits of a*b; carry = (high half != 0); overflow=0.
- Flags: zero and negative derive from the registered result for every op.
- Boundaries:
  - Shift amount WIDTH-1 is legal; upper bits of b are ignored.
  - in_valid while in_ready=0 is ignored. The source must hold in_valid, per valid/ready rules.
  - Input values never affect a held result in DONE.

Optional Feature:
- ALU_MUL_EN defined: op 111 is the WIDTH-cycle shift-add multiplier described above.
- ALU_MUL_EN undefined:
  - MUL_BUSY state, counter and multiplier registers are not built.
  - Op 111 completes in 1 cycle like any other op, with result=0, zero=1, and carry=negative=overflow=0.

Test Plan (WIDTH=8 unless stated):
- ADD a=0xFF, b=0x01, out_ready=1 -> 1 cycle later out_valid=1, result=0x00, zero=1, carry=1, overflow=0; next cycle in_ready=1.
- SUB a=0x80, b=0x01 -> result=0x7F, overflow=1, carry=0, negative=0. SUB a=0x01, b=0x02 -> result=0xFF, carry=1, negative=1.
- SLL a=0x81, b=0x09 (amount 1) -> result=0x02, carry=1. SRL a=0x01, b=0x00 -> result=0x01, carry=0.
- ALU_MUL_EN on:
  - MUL a=0x10, b=0x11 -> out_valid exactly 9 cycles after acceptance, result=0x10, carry=1.
  - MUL a=0x0F, b=0x0F -> result=0xE1, carry=0.
  - in_ready=0 throughout MUL_BUSY.
- Backpressure: hold out_ready=0 for 5 cycles after XOR a=0xAA, b=0x55 -> result=0xFF held stable, in_ready=0; new in_valid is ignored until out_ready=1.
- Assert rst during MUL_BUSY -> immediately out_valid=0, in_ready=1, result=0; the next ADD 0x02+0x03 returns 0x05.
